commit_stage_multi: RTL and testbench
=====================================

// Module: commit_stage_multi
// PURPOSE
//  Parametrised N-port in-order commit stage between the scoreboard and the register files / CSR file / LSU.
//  Retires the longest eligible prefix of the N head entries each cycle.
//  Serialising ops (FENCE, FENCE.I, SFENCE.VMA, AMO) go through an explicit drain/flush FSM instead of stalling combinationally.
//  Optionally keeps a retired-instruction counter.
// PARAMETERS
//  NR_COMMIT_PORTS  4   number of head entries examined per cycle (1..8)
//  XLEN             64  data width of results and CSR write data
//  TRANS_ID_BITS    3   scoreboard transaction-id width
//  CNT_W            64  width of the instret counter
// PORTS
//  clk_i              in   1             clock
//  rst_ni             in   1             asynchronous reset, active low
//  flush_i            in   1             controller flush; FSM returns to IDLE
//  halt_i             in   1             halt request; no new retirement
//  single_step_i      in   1             debug single step; retire at most 1 per cycle
//  instr_i            in   N x commit_entry_t  head entries {valid, ex, cls, op, rd, is_fpr, result, trans_id}
//  commit_ack_o       out  N             entry k retired this cycle (always a contiguous prefix)
//  waddr_o            out  N x 5         register write address (= instr_i[k].rd)
//  wdata_o            out  N x XLEN      register write data
//  we_gpr_o/we_fpr_o  out  N each        integer / FP register write enables
//  commit_lsu_o       out  1             commit one pending store
//  commit_lsu_ready_i in   1             store buffer can accept a commit
//  commit_tran_id_o   out  TRANS_ID_BITS trans_id of the retiring store, else port 0
//  no_st_pending_i    in   1             store buffer empty
//  csr_op_o           out  fu_op         CSR operation; ADD = NOP
//  csr_wdata_o        out  XLEN          CSR write data, or fflags
//  csr_rdata_i        in   XLEN          CSR read data
//  csr_exception_i    in   exception_t   CSR exception for port 0
//  csr_write_fflags_o out  1             write the fflags CSR
//  commit_csr_o       out  1             commit the CSR op on port 0
//  amo_valid_commit_o out  1             AMO may execute
//  amo_resp_i         in   amo_resp_t    {ack, result} of the AMO
//  fence_o, fence_i_o, sfence_vma_o  out  1 each  one-cycle flush requests
//  flush_commit_o     out  1             pipeline flush after an AMO
//  exception_o        out  exception_t   exception taken at port 0
//  instret_o          out  CNT_W         retired-instruction count
// BEHAVIOUR
//  - Reset: state=IDLE, instret_o=0. With no valid input, every output is 0, except csr_op_o=ADD.
//  - Eligibility, port 0: valid & !ex.valid & !halt_i & state==IDLE. Additionally:
//    - STORE needs commit_lsu_ready_i.
//    - CSR needs !csr_exception_i.valid; on success wdata_o[0]=csr_rdata_i and commit_csr_o=1.
//  - Eligibility, port k>0: lower port acked & valid & !ex.valid & !single_step_i & port 0 not CSR/SERIAL/AMO.
//    - cls must be in {ALU, LOAD, CTRL, MULT, FPU, STORE}.
//    - At most one STORE per cycle, and it needs commit_lsu_ready_i; the first ineligible port ends the prefix.
//  - commit_lsu_o=1 when a STORE is in the acked prefix. commit_tran_id_o is that store's trans_id, else instr_i[0].trans_id.
//  - Register write enables: we_fpr_o[k]=ack&is_fpr and we_gpr_o[k]=ack&!is_fpr. Neither is asserted for a CSR that takes an exception.
//  - fflags: if any acked port is FPU, csr_write_fflags_o=1 and csr_wdata_o = OR of ex.cause[4:0] over all acked FPU ports.
//  - FSM, state IDLE: a non-excepting, unhalted SERIAL op at port 0 moves to FLUSH if no_st_pending_i, else to DRAIN.
//    An AMO at port 0 moves to AMO_WAIT. There is no ack in the entry cycle.
//  - FSM, state DRAIN: hold until no_st_pending_i, then go to FLUSH. halt_i and new inputs are ignored.
//  - FSM, state FLUSH: for exactly one cycle, pulse fence_o, fence_i_o or sfence_vma_o by op and assert commit_ack_o[0]. Then go to IDLE.
//  - FSM, state AMO_WAIT: amo_valid_commit_o=1. On amo_resp_i.ack, in the same cycle:
//    - commit_ack_o[0]=1, we_gpr_o[0]=1, wdata_o[0]=amo result, flush_commit_o=1; then go to IDLE.
//    - halt_i does not abort AMO_WAIT.
//  - flush_i in any state: next state is IDLE and no ack that cycle. flush_i wins over a simultaneous FLUSH or amo ack.
//  - Exceptions (combinational, port 0 valid only): ex.valid has priority over csr_exception_i. The tval is taken from instr_i[0].ex.tval.
//    An excepting entry is never acked. halt_i forces exception_o.valid=0.
//  - Reset asserted mid-DRAIN/AMO_WAIT: FSM goes to IDLE immediately and all pulses drop.
// CONFIGURATION
//  COMMIT_INSTRET_EN defined: instret_o <= instret_o + popcount(commit_ack_o) each cycle, wrapping modulo 2^CNT_W.
//  COMMIT_INSTRET_EN undefined: instret_o tied to 0 and no counter flops.
// STRUCTURE
//  ariane_pkg holds commit_class_e {ALU, LOAD, STORE, CTRL, MULT, FPU, CSR, SERIAL, AMO}, commit_entry_t and commit_state_e.
//  Sub-module commit_serial_fsm holds the IDLE/DRAIN/FLUSH/AMO_WAIT FSM and drives the fence/amo outputs.
//  Prefix and eligibility logic stay in the top module.
// TESTING
//  - 4 valid ALU ops, no ex -> commit_ack_o=4'b1111; with CNT_W=64 and COMMIT_INSTRET_EN, instret_o=4 next cycle.
//  - ALU, STORE, STORE, ALU with lsu_ready=1 -> ack=4'b0011; commit_lsu_o=1; commit_tran_id_o = port 1 trans_id.
//  - FENCE at port 0 with no_st_pending_i=0 for 3 cycles -> DRAIN for 3 cycles; then FLUSH with fence_o=1 and ack[0]=1 for exactly 1 cycle.
//  - AMO at port 0, amo ack after 5 cycles -> amo_valid_commit_o high for 5 cycles; ack cycle gives we_gpr_o[0]=1, wdata_o[0]=result, flush_commit_o=1.
//  - FPU ops at ports 0 and 1 with causes 5'h01 and 5'h04 -> csr_wdata_o=5'h05, csr_write_fflags_o=1.
//  - Port 0 with ex.valid=1 and halt_i=0 -> exception_o=ex and ack=0; raise halt_i -> exception_o.valid=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types for the commit stage: instruction classes, scoreboard head entries,
// exception/AMO response records and the serialising-FSM state encoding.
package ariane_pkg;

  localparam int unsigned PKG_XLEN     = 64;
  localparam int unsigned PKG_TID_BITS = 3;

  typedef enum logic [3:0] {
    ALU, LOAD, STORE, CTRL, MULT, FPU, CSR, SERIAL, AMO
  } commit_class_e;

  typedef enum logic [3:0] {
    ADD, CSR_WRITE, CSR_READ, CSR_SET, CSR_CLEAR,
    FENCE, FENCE_I, SFENCE_VMA, AMO_SWAP, AMO_ADDW
  } fu_op;

  typedef struct packed {
    logic                valid;
    logic [PKG_XLEN-1:0] cause;
    logic [PKG_XLEN-1:0] tval;
  } exception_t;

  // For FPU entries ex.cause[4:0] carries the accrued fflags while ex.valid stays 0.
  typedef struct packed {
    logic                    valid;
    exception_t              ex;
    commit_class_e           cls;
    fu_op                    op;
    logic [4:0]              rd;
    logic                    is_fpr;
    logic [PKG_XLEN-1:0]     result;
    logic [PKG_TID_BITS-1:0] trans_id;
  } commit_entry_t;

  typedef struct packed {
    logic                ack;
    logic [PKG_XLEN-1:0] result;
  } amo_resp_t;

  typedef logic [1:0] commit_state_e;
  localparam commit_state_e ST_IDLE     = 2'd0;
  localparam commit_state_e ST_DRAIN    = 2'd1;
  localparam commit_state_e ST_FLUSH    = 2'd2;
  localparam commit_state_e ST_AMO_WAIT = 2'd3;

  // Classes that may retire at any port without side effects beyond a register write.
  function automatic logic is_simple(input commit_class_e c);
    return c inside {ALU, LOAD, CTRL, MULT, FPU};
  endfunction

endpackage

// File: rtl/commit_serial_fsm.sv
// Drain/flush FSM for serialising ops (FENCE, FENCE.I, SFENCE.VMA) and AMOs at the
// commit head. Retires port 0 itself in FLUSH and on the AMO response.
module commit_serial_fsm
  import ariane_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          halt_i,
  input  logic          head_ok_i,
  input  commit_class_e cls_i,
  input  fu_op          op_i,
  input  logic          no_st_pending_i,
  input  logic          amo_ack_i,
  output commit_state_e state_o,
  output logic          ack_o,
  output logic          amo_commit_o,
  output logic          amo_valid_commit_o,
  output logic          fence_o,
  output logic          fence_i_o,
  output logic          sfence_vma_o,
  output logic          flush_commit_o
);

  commit_state_e state_q, state_d;
  fu_op          op_q, op_d;
  logic          flush_pulse;
  logic          amo_done;

  // AMO handshake: amo_valid_commit_o stays high for the whole AMO_WAIT stay and the
  // LSU answers with a one-cycle amo_resp ack; that same cycle retires port 0.
  assign amo_valid_commit_o = (state_q == ST_AMO_WAIT);
  assign amo_done           = (state_q == ST_AMO_WAIT) && amo_ack_i && !flush_i;
  assign flush_pulse        = (state_q == ST_FLUSH) && !flush_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (head_ok_i && !halt_i) begin
          if (cls_i == SERIAL) begin
            state_d = no_st_pending_i ? ST_FLUSH : ST_DRAIN;
            op_d    = op_i;
          end else if (cls_i == AMO) begin
            state_d = ST_AMO_WAIT;
          end
        end
      end
      ST_DRAIN:    if (no_st_pending_i) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_IDLE;
      ST_AMO_WAIT: if (amo_ack_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign state_o        = state_q;
  assign ack_o          = flush_pulse || amo_done;
  assign amo_commit_o   = amo_done;
  assign flush_commit_o = amo_done;
  assign fence_o        = flush_pulse && (op_q == FENCE);
  assign fence_i_o      = flush_pulse && (op_q == FENCE_I);
  assign sfence_vma_o   = flush_pulse && (op_q == SFENCE_VMA);

endmodule

// File: rtl/commit_stage_multi.sv
// N-port in-order commit stage: retires the longest eligible prefix of the head entries.
// Define COMMIT_INSTRET_EN to keep a retired-instruction counter on instret_o.
module commit_stage_multi
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 4,
  parameter int unsigned XLEN            = PKG_XLEN,
  parameter int unsigned TRANS_ID_BITS   = PKG_TID_BITS,
  parameter int unsigned CNT_W           = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       halt_i,
  input  logic                       single_step_i,
  input  commit_entry_t              instr_i [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0] commit_ack_o,
  output logic [4:0]                 waddr_o [NR_COMMIT_PORTS],
  output logic [XLEN-1:0]            wdata_o [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0] we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0] we_fpr_o,
  output logic                       commit_lsu_o,
  input  logic                       commit_lsu_ready_i,
  output logic [TRANS_ID_BITS-1:0]   commit_tran_id_o,
  input  logic                       no_st_pending_i,
  output fu_op                       csr_op_o,
  output logic [XLEN-1:0]            csr_wdata_o,
  input  logic [XLEN-1:0]            csr_rdata_i,
  input  exception_t                 csr_exception_i,
  output logic                       csr_write_fflags_o,
  output logic                       commit_csr_o,
  output logic                       amo_valid_commit_o,
  input  amo_resp_t                  amo_resp_i,
  output logic                       fence_o,
  output logic                       fence_i_o,
  output logic                       sfence_vma_o,
  output logic                       flush_commit_o,
  output exception_t                 exception_o,
  output logic [CNT_W-1:0]           instret_o
);

  commit_state_e              state;
  commit_class_e              cls0;
  logic                       fsm_ack, amo_commit;
  logic                       head_ok, base0, csr_head;
  logic [NR_COMMIT_PORTS-1:0] ack;
  logic                       store_seen;
  logic [4:0]                 fflags;
  logic                       fflags_we;
  logic                       unused_bits;

  assign cls0     = instr_i[0].cls;
  assign head_ok  = instr_i[0].valid && !instr_i[0].ex.valid;
  assign base0    = head_ok && !halt_i && !flush_i && (state == ST_IDLE);
  assign csr_head = base0 && (cls0 == CSR);

  commit_serial_fsm u_fsm (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .halt_i             (halt_i),
    .head_ok_i          (head_ok),
    .cls_i              (cls0),
    .op_i               (instr_i[0].op),
    .no_st_pending_i    (no_st_pending_i),
    .amo_ack_i          (amo_resp_i.ack),
    .state_o            (state),
    .ack_o              (fsm_ack),
    .amo_commit_o       (amo_commit),
    .amo_valid_commit_o (amo_valid_commit_o),
    .fence_o            (fence_o),
    .fence_i_o          (fence_i_o),
    .sfence_vma_o       (sfence_vma_o),
    .flush_commit_o     (flush_commit_o)
  );

  // Prefix build: each port needs the one below it acked, so the first refusal ends it.
  always_comb begin
    ack = '0;
    if (base0) begin
      case (cls0)
        ALU, LOAD, CTRL, MULT, FPU: ack[0] = 1'b1;
        STORE:                      ack[0] = commit_lsu_ready_i;
        CSR:                        ack[0] = !csr_exception_i.valid;
        default:                    ack[0] = 1'b0;
      endcase
    end
    if (fsm_ack) ack[0] = 1'b1;
    store_seen = ack[0] && (cls0 == STORE);
    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
      if (ack[k-1] && instr_i[k].valid && !instr_i[k].ex.valid && !single_step_i &&
          !(cls0 inside {CSR, SERIAL, AMO}) &&
          (is_simple(instr_i[k].cls) ||
           (instr_i[k].cls == STORE && commit_lsu_ready_i && !store_seen))) begin
        ack[k] = 1'b1;
        if (instr_i[k].cls == STORE) store_seen = 1'b1;
      end
    end
  end

  assign commit_ack_o = ack;

  always_comb begin
    commit_lsu_o     = 1'b0;
    commit_tran_id_o = instr_i[0].trans_id;
    fflags           = '0;
    fflags_we        = 1'b0;
    unused_bits      = ^csr_exception_i.tval;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      waddr_o[k]  = instr_i[k].rd;
      wdata_o[k]  = instr_i[k].result;
      we_gpr_o[k] = ack[k] && !instr_i[k].is_fpr;
      we_fpr_o[k] = ack[k] && instr_i[k].is_fpr;
      unused_bits = unused_bits ^ (^instr_i[k]);
      if (ack[k] && instr_i[k].cls == STORE) begin
        commit_lsu_o     = 1'b1;
        commit_tran_id_o = instr_i[k].trans_id;
      end
      if (ack[k] && instr_i[k].cls == FPU) begin
        fflags_we = 1'b1;
        fflags    = fflags | instr_i[k].ex.cause[4:0];
      end
    end
    if (ack[0] && cls0 == CSR) wdata_o[0] = csr_rdata_i;
    if (amo_commit) begin
      wdata_o[0]  = amo_resp_i.result;
      we_gpr_o[0] = 1'b1;
      we_fpr_o[0] = 1'b0;
    end
  end

  assign csr_op_o           = csr_head ? instr_i[0].op : ADD;
  assign commit_csr_o       = ack[0] && (cls0 == CSR);
  assign csr_write_fflags_o = fflags_we;
  assign csr_wdata_o        = fflags_we ? XLEN'(fflags) :
                              csr_head  ? instr_i[0].result : '0;

  // The instruction's own exception outranks one raised by the CSR file.
  always_comb begin
    exception_o = '0;
    if (instr_i[0].valid && !halt_i) begin
      if (instr_i[0].ex.valid) begin
        exception_o = instr_i[0].ex;
      end else if (cls0 == CSR && csr_exception_i.valid) begin
        exception_o      = csr_exception_i;
        exception_o.tval = instr_i[0].ex.tval;
      end
    end
  end

`ifdef COMMIT_INSTRET_EN
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] ret_cnt;

  always_comb begin
    ret_cnt = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) ret_cnt = ret_cnt + CNT_W'(ack[k]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) instret_q <= '0;
    else         instret_q <= instret_q + ret_cnt;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_commit_stage_multi.sv
// Directed bench for commit_stage_multi: table-driven prefix/eligibility vectors plus
// hand-written sequences for the drain/flush and AMO paths.
module tb_commit_stage_multi
  import ariane_pkg::*;
;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            halt;
  logic            sstep;
  commit_entry_t   instr [4];
  logic [3:0]      ack;
  logic [4:0]      waddr [4];
  logic [63:0]     wdata [4];
  logic [3:0]      we_gpr, we_fpr;
  logic            lsu;
  logic            lsu_rdy;
  logic [2:0]      tid;
  logic            no_st;
  fu_op            csr_op;
  logic [63:0]     csr_wdata;
  logic [63:0]     csr_rdata;
  exception_t      csr_ex;
  logic            ffwe;
  logic            commit_csr;
  logic            amo_valid;
  amo_resp_t       amo_resp;
  logic            fence, fence_i, sfence;
  logic            flush_commit;
  exception_t      exc;
  logic [63:0]     instret;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] exp_ret = '0;

  commit_stage_multi dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .halt_i             (halt),
    .single_step_i      (sstep),
    .instr_i            (instr),
    .commit_ack_o       (ack),
    .waddr_o            (waddr),
    .wdata_o            (wdata),
    .we_gpr_o           (we_gpr),
    .we_fpr_o           (we_fpr),
    .commit_lsu_o       (lsu),
    .commit_lsu_ready_i (lsu_rdy),
    .commit_tran_id_o   (tid),
    .no_st_pending_i    (no_st),
    .csr_op_o           (csr_op),
    .csr_wdata_o        (csr_wdata),
    .csr_rdata_i        (csr_rdata),
    .csr_exception_i    (csr_ex),
    .csr_write_fflags_o (ffwe),
    .commit_csr_o       (commit_csr),
    .amo_valid_commit_o (amo_valid),
    .amo_resp_i         (amo_resp),
    .fence_o            (fence),
    .fence_i_o          (fence_i),
    .sfence_vma_o       (sfence),
    .flush_commit_o     (flush_commit),
    .exception_o        (exc),
    .instret_o          (instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    v;
    logic [3:0]    xv;
    commit_class_e c [4];
    logic [19:0]   fl;
    logic          halt;
    logic          sstep;
    logic          lsu_rdy;
    logic          csr_ex;
    logic [3:0]    ack;
    logic          lsu;
    logic [2:0]    tid;
    logic          ffwe;
    logic [63:0]   cwdata;
    logic          exv;
    logic          csr;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic commit_entry_t ent(input logic v, input logic xv, input commit_class_e c,
                                        input int k, input logic [4:0] fl);
    commit_entry_t e;
    e = '0;
    if (v) begin
      e.valid    = 1'b1;
      e.ex.valid = xv;
      e.ex.cause = 64'(fl);
      e.cls      = c;
      e.rd       = 5'(k + 1);
      e.is_fpr   = (c == FPU);
      e.result   = 64'h100 + 64'(k);
      e.trans_id = 3'(k + 1);
    end
    return e;
  endfunction

  // driver tasks
  task automatic clear_inputs();
    flush    = 1'b0;
    halt     = 1'b0;
    sstep    = 1'b0;
    lsu_rdy  = 1'b1;
    no_st    = 1'b1;
    csr_ex   = '0;
    amo_resp = '0;
    for (int k = 0; k < 4; k++) instr[k] = '0;
  endtask

  task automatic head(input commit_class_e c, input fu_op op);
    for (int k = 0; k < 4; k++) instr[k] = '0;
    instr[0]    = ent(1'b1, 1'b0, c, 0, 5'd0);
    instr[0].op = op;
  endtask

  task automatic apply(input vec_t t);
    halt    = t.halt;
    sstep   = t.sstep;
    lsu_rdy = t.lsu_rdy;
    csr_ex  = '{valid: t.csr_ex, cause: 64'h2, tval: 64'h0};
    for (int k = 0; k < 4; k++)
      instr[k] = ent(t.v[k], t.xv[k], t.c[k], k, t.fl[k*5 +: 5]);
  endtask

  task automatic count_ret(input int n);
`ifdef COMMIT_INSTRET_EN
    exp_ret = exp_ret + 64'(n);
`else
    exp_ret = exp_ret + 64'(n) * 64'h0;
`endif
  endtask

  initial begin
    logic [3:0] fpr_m;
    // {v, xv, classes, flags, halt, sstep, lsu_rdy, csr_ex, ack, lsu, tid, ffwe, cwdata, exv, csr}
    vt[0]  = '{4'b0000, 4'b0000, '{ALU, ALU, ALU, ALU},     20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[1]  = '{4'b1111, 4'b0000, '{ALU, ALU, ALU, ALU},     20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[2]  = '{4'b1111, 4'b0000, '{ALU, STORE, STORE, ALU}, 20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b1, 3'd2, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[3]  = '{4'b1111, 4'b0000, '{ALU, STORE, STORE, ALU}, 20'h0,     1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[4]  = '{4'b0111, 4'b0000, '{FPU, FPU, ALU, ALU},     20'h00081, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0, 3'd1, 1'b1, 64'h5,   1'b0, 1'b0};
    vt[5]  = '{4'b1111, 4'b0000, '{ALU, ALU, ALU, ALU},     20'h0,     1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[6]  = '{4'b1111, 4'b0000, '{ALU, ALU, ALU, ALU},     20'h0,     1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[7]  = '{4'b1111, 4'b0000, '{CSR, ALU, ALU, ALU},     20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 64'h100, 1'b0, 1'b1};
    vt[8]  = '{4'b0001, 4'b0000, '{CSR, ALU, ALU, ALU},     20'h0,     1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b0, 64'h100, 1'b1, 1'b0};
    vt[9]  = '{4'b1111, 4'b0100, '{ALU, LOAD, ALU, ALU},    20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[10] = '{4'b1110, 4'b0000, '{ALU, ALU, ALU, ALU},     20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[11] = '{4'b1111, 4'b0000, '{ALU, SERIAL, ALU, ALU},  20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[12] = '{4'b1111, 4'b0000, '{STORE, ALU, ALU, ALU},   20'h0,     1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[13] = '{4'b1111, 4'b0000, '{ALU, ALU, ALU, STORE},   20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 3'd4, 1'b0, 64'h0,   1'b0, 1'b0};
    vt[14] = '{4'b1111, 4'b0000, '{MULT, CTRL, AMO, ALU},   20'h0,     1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 3'd1, 1'b0, 64'h0,   1'b0, 1'b0};

    csr_rdata = 64'hC5C5_0000_1234_5678;
    clear_inputs();
    rst_n = 1'b0;
    #3;
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_csr_op", 64'(csr_op), 64'(ADD));
    chk("rst_instret", instret, 64'h0);
    chk("rst_amo_valid", 64'(amo_valid), 64'h0);
    chk("rst_fence", 64'({fence, fence_i, sfence, flush_commit}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors, all with the FSM idle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      fpr_m = '0;
      for (int k = 0; k < 4; k++) fpr_m[k] = vt[i].v[k] && (vt[i].c[k] == FPU);
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vt[i].ack));
      chk($sformatf("v%0d_lsu", i), 64'(lsu), 64'(vt[i].lsu));
      chk($sformatf("v%0d_tid", i), 64'(tid), 64'(vt[i].tid));
      chk($sformatf("v%0d_ffwe", i), 64'(ffwe), 64'(vt[i].ffwe));
      chk($sformatf("v%0d_csr_wdata", i), csr_wdata, vt[i].cwdata);
      chk($sformatf("v%0d_exv", i), 64'(exc.valid), 64'(vt[i].exv));
      chk($sformatf("v%0d_commit_csr", i), 64'(commit_csr), 64'(vt[i].csr));
      chk($sformatf("v%0d_we_gpr", i), 64'(we_gpr), 64'(vt[i].ack & ~fpr_m));
      chk($sformatf("v%0d_we_fpr", i), 64'(we_fpr), 64'(vt[i].ack & fpr_m));
      if (vt[i].csr) chk($sformatf("v%0d_csr_rdata", i), wdata[0], csr_rdata);
      @(posedge clk);
      #1;
      count_ret($countones(vt[i].ack));
      chk($sformatf("v%0d_instret", i), instret, exp_ret);
    end

    // FENCE with stores pending: entry, three DRAIN cycles (halt ignored), one FLUSH
    @(negedge clk); clear_inputs(); head(SERIAL, FENCE); no_st = 1'b0;
    #1; chk("fence_entry_ack", 64'(ack), 64'h0); chk("fence_entry_pulse", 64'(fence), 64'h0);
    @(negedge clk); #1; chk("drain1_ack", 64'(ack), 64'h0); chk("drain1_fence", 64'(fence), 64'h0);
    @(negedge clk); halt = 1'b1;
    #1; chk("drain2_ack", 64'(ack), 64'h0); chk("drain2_fence", 64'(fence), 64'h0);
    @(negedge clk); halt = 1'b0; no_st = 1'b1;
    #1; chk("drain3_ack", 64'(ack), 64'h0); chk("drain3_fence", 64'(fence), 64'h0);
    @(negedge clk);
    #1; chk("flush_fence", 64'(fence), 64'h1); chk("flush_ack", 64'(ack), 64'h1);
    chk("flush_other_pulses", 64'({fence_i, sfence}), 64'h0);
    count_ret(1);
    @(negedge clk); clear_inputs();
    #1; chk("post_flush_fence", 64'(fence), 64'h0); chk("post_flush_ack", 64'(ack), 64'h0);

    // FENCE.I with an empty store buffer goes straight to FLUSH
    @(negedge clk); head(SERIAL, FENCE_I);
    #1; chk("fencei_entry_ack", 64'(ack), 64'h0);
    @(negedge clk);
    #1; chk("fencei_pulse", 64'(fence_i), 64'h1); chk("fencei_ack", 64'(ack), 64'h1);
    count_ret(1);
    @(negedge clk); clear_inputs();

    // SFENCE.VMA killed by flush_i in its FLUSH cycle
    @(negedge clk); head(SERIAL, SFENCE_VMA);
    @(negedge clk); flush = 1'b1;
    #1; chk("sfence_flushed_pulse", 64'(sfence), 64'h0); chk("sfence_flushed_ack", 64'(ack), 64'h0);
    @(negedge clk); clear_inputs();
    #1; chk("sfence_after_flush", 64'(sfence), 64'h0);

    // AMO: 5 cycles of amo_valid_commit_o, response in the 5th (halt does not abort)
    @(negedge clk); head(AMO, AMO_SWAP);
    #1; chk("amo_entry_ack", 64'(ack), 64'h0); chk("amo_entry_valid", 64'(amo_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); halt = (i == 1);
      #1; chk($sformatf("amo_wait%0d_valid", i), 64'(amo_valid), 64'h1);
      chk($sformatf("amo_wait%0d_ack", i), 64'(ack), 64'h0);
    end
    @(negedge clk); halt = 1'b0; amo_resp = '{ack: 1'b1, result: 64'hCAFE_F00D_0000_0042};
    #1;
    chk("amo_resp_valid", 64'(amo_valid), 64'h1);
    chk("amo_resp_ack", 64'(ack), 64'h1);
    chk("amo_resp_we_gpr", 64'(we_gpr), 64'h1);
    chk("amo_resp_wdata", wdata[0], 64'hCAFE_F00D_0000_0042);
    chk("amo_resp_flush_commit", 64'(flush_commit), 64'h1);
    count_ret(1);
    @(negedge clk); clear_inputs();
    #1; chk("amo_done_valid", 64'(amo_valid), 64'h0); chk("amo_done_flush_commit", 64'(flush_commit), 64'h0);

    // flush_i beats a simultaneous AMO response
    @(negedge clk); head(AMO, AMO_ADDW);
    @(negedge clk); flush = 1'b1; amo_resp = '{ack: 1'b1, result: 64'h77};
    #1; chk("amo_flush_ack", 64'(ack), 64'h0); chk("amo_flush_commit", 64'(flush_commit), 64'h0);
    @(negedge clk); flush = 1'b0; amo_resp = '0;
    #1; chk("amo_flush_idle", 64'(amo_valid), 64'h0);
    @(negedge clk); clear_inputs();

    // exception at port 0, then masked by halt
    @(negedge clk);
    instr[0] = ent(1'b1, 1'b1, ALU, 0, 5'd2);
    instr[0].ex.tval = 64'hDEAD_BEEF;
    #1;
    chk("exc_valid", 64'(exc.valid), 64'h1);
    chk("exc_cause", exc.cause, 64'h2);
    chk("exc_tval", exc.tval, 64'hDEAD_BEEF);
    chk("exc_ack", 64'(ack), 64'h0);
    halt = 1'b1;
    #1; chk("exc_halt_valid", 64'(exc.valid), 64'h0);
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    chk("instret_before_reset", instret, exp_ret);

    // asynchronous reset while waiting on an AMO
    @(negedge clk); head(AMO, AMO_SWAP);
    @(negedge clk);
    #1; chk("rst_amo_pre", 64'(amo_valid), 64'h1);
    #2; rst_n = 1'b0;
    #1; chk("rst_amo_valid", 64'(amo_valid), 64'h0); chk("rst_mid_instret", instret, 64'h0);
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
    #1; chk("post_rst_ack", 64'(ack), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
